tron_move_ctrl: RTL and testbench
=================================

# tron_move_ctrl

Per-tick movement sequencer for the two TRON light-cycles. It filters steering requests so a player cannot reverse onto its own trail. On each game tick it computes both players' next cells, arbitrates the single-port trail grid between them (two reads, then two writes), and resolves wall, trail and head-on collisions into game-over and winner outputs. It sits between the keyboard/controller decoders and the trail-grid RAM, and feeds positions to the VGA renderer.

## Interface
- GRID_W, 160, grid width in cells
- GRID_H, 120, grid height in cells
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- P1_X0 / P1_Y0, 20 / 60, P1 start cell; P1 start direction RIGHT
- P2_X0 / P2_Y0, 140 / 60, P2 start cell; P2 start direction LEFT

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- resetn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-step pulse
- p1_req_valid, p2_req_valid  in  1  steering request strobe
- p1_req_dir, p2_req_dir  in  2  requested direction: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT
- grid_x / grid_y  out  X_W / Y_W  grid RAM address
- grid_re  out  1  grid read enable
- grid_rd_occ  in  1  cell-occupied flag, valid one cycle after grid_re
- grid_we  out  1  grid write enable
- grid_wr_id  out  2  owner written to the cell: 01 P1, 10 P2
- p1_x, p1_y, p2_x, p2_y  out  X_W/Y_W  current head cells
- p1_dir, p2_dir  out  2  committed directions
- busy  out  1  high whenever the FSM is not in IDLE
- game_over  out  1  sticky end flag
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
- Each player has a pending direction and a committed direction. On req_valid, pending is loaded unless req_dir equals committed XOR 2'b10 (the reversal); reversals are dropped silently.
- FSM states: INIT1, INIT2, IDLE, RD1, RD2, CHK, WR1, WR2, DEAD.
- INIT1/INIT2 write the P1 and P2 start cells with their ids, then go to IDLE.
- In IDLE, a tick copies pending to committed, computes next cells, and moves to RD1.
- RD1 reads the P1 next cell. RD2 reads the P2 next cell and captures P1 occupancy. CHK captures P2 occupancy.
- A player is dead if any of these holds: its next cell is off-grid (x=0 moving LEFT, x=GRID_W-1 moving RIGHT, y=0 moving UP, y=GRID_H-1 moving DOWN), its next cell is occupied, or both next cells are equal (both players dead).
- Reads for an off-grid next cell are still issued with the clamped current cell; the result is ignored.
- CHK with no deaths: go to WR1, which writes the P1 next cell with id 01, then WR2, which writes the P2 next cell with id 10. Head positions update at the end of WR2, then return to IDLE.
- CHK with any death: go to DEAD. No writes, positions frozen, game_over=1, winner set as follows: P2 dead only gives 01; P1 dead only gives 10; both dead gives 11.
- DEAD is held until resetn. Ticks and requests are ignored there.
- A tick arriving while busy is dropped; it is not queued.
- A request in the same cycle as a tick lands in pending and takes effect on the following tick.

## Timing
- Reset values: positions = start cells, p1_dir=RIGHT, p2_dir=LEFT, pendings equal committed, state INIT1, busy=1, grid_we=0, grid_re=0, game_over=0, winner=00.
- busy falls in the third cycle after reset release.
- With tick sampled in cycle 0:
  - RD1 in cycle 1, RD2 in cycle 2, CHK in cycle 3, WR1 in cycle 4, WR2 in cycle 5.
  - New positions are visible in cycle 6; busy is high for cycles 1-5.
  - game_over rises in cycle 4 on a collision.
- All outputs are registered. grid_re and grid_we are never high together.
- Reset mid-sequence aborts immediately; any partial grid writes are the RAM owner's concern.

## Structure
- tron_pkg: direction codes, opposite-direction function, player id codes, FSM state enum, default grid dimensions.
- One sub-module, tron_dir_filter, instantiated per player. It holds the pending and committed registers and does the reversal rejection.
- The grid RAM stays outside this block.

## Test plan
- Reset release: INIT writes (20,60,id01) then (140,60,id10); busy=0 by cycle 3; p1_dir=01, p2_dir=11.
- P1 requests LEFT (reversal), then tick: p1_dir stays 01 and P1 moves to (21,60). Request UP, then tick: P1 moves to (21,59).
- Empty grid, one tick: exactly two reads then two writes, at (21,60) and (139,60); new positions in cycle 6.
- P1 at x=159 moving RIGHT, tick: no writes, game_over=1, winner=10.
- Players one apart on row 60 (x=79 RIGHT, x=81 LEFT), tick: next cells are equal, winner=11.
- Tick pulsed during busy (cycle 3): ignored, a single step occurs. After game_over, ticks change nothing until resetn.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared types and constants for the TRON light-cycle movement controller:
// direction and owner codes, sequencer states and default grid size.
package tron_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   localparam logic [1:0] ID_P1 = 2'b01;
   localparam logic [1:0] ID_P2 = 2'b10;

   typedef enum logic [3:0] {
      ST_INIT1,
      ST_INIT2,
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_CHK,
      ST_WR1,
      ST_WR2,
      ST_DEAD
   } state_t;

   localparam int unsigned GRID_W_DEF = 160;
   localparam int unsigned GRID_H_DEF = 120;

   // Opposite directions differ only in the upper bit of the code.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/tron_dir_filter.sv
// Per-player steering filter: holds the pending and committed directions and
// drops requests that would reverse the cycle onto its own trail.
module tron_dir_filter
   import tron_pkg::*;
#(
   parameter dir_t DIR0 = DIR_RIGHT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   input  dir_t req_dir,
   input  logic commit,
   output dir_t pending,
   output dir_t committed
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= DIR0;
         committed <= DIR0;
      end else begin
         if (commit) begin
            committed <= pending;
         end
         // A request arriving with a commit is judged against the old direction
         // and only takes effect on the following commit.
         if (req_valid && (req_dir != opposite(committed))) begin
            pending <= req_dir;
         end
      end
   end

endmodule

// File: rtl/tron_move_ctrl.sv
// Per-tick movement sequencer for the two light-cycles: next-cell computation,
// two reads then two writes on the shared trail grid, and collision resolution.
module tron_move_ctrl
   import tron_pkg::*;
#(
   parameter int unsigned GRID_W = GRID_W_DEF,
   parameter int unsigned GRID_H = GRID_H_DEF,
   parameter int unsigned X_W    = 8,
   parameter int unsigned Y_W    = 7,
   parameter int unsigned P1_X0  = 20,
   parameter int unsigned P1_Y0  = 60,
   parameter int unsigned P2_X0  = 140,
   parameter int unsigned P2_Y0  = 60
) (
   input  logic           CLOCK_50,
   input  logic           resetn,
   input  logic           tick,
   input  logic           p1_req_valid,
   input  logic           p2_req_valid,
   input  logic [1:0]     p1_req_dir,
   input  logic [1:0]     p2_req_dir,
   output logic [X_W-1:0] grid_x,
   output logic [Y_W-1:0] grid_y,
   output logic           grid_re,
   input  logic           grid_rd_occ,
   output logic           grid_we,
   output logic [1:0]     grid_wr_id,
   output logic [X_W-1:0] p1_x,
   output logic [Y_W-1:0] p1_y,
   output logic [X_W-1:0] p2_x,
   output logic [Y_W-1:0] p2_y,
   output logic [1:0]     p1_dir,
   output logic [1:0]     p2_dir,
   output logic           busy,
   output logic           game_over,
   output logic [1:0]     winner
);

   state_t         state;
   dir_t           p1_pend, p1_cmt, p2_pend, p2_cmt;
   logic           commit, p1_req_ok, p2_req_ok;
   logic [X_W-1:0] c1_x, c2_x, n1_x, n2_x;
   logic [Y_W-1:0] c1_y, c2_y, n1_y, n2_y;
   logic           c1_off, c2_off, off1, off2, occ1;
   logic           same, dead1, dead2;

   assign commit    = (state == ST_IDLE) && tick;
   assign p1_req_ok = p1_req_valid && (state != ST_DEAD);
   assign p2_req_ok = p2_req_valid && (state != ST_DEAD);
   assign p1_dir    = p1_cmt;
   assign p2_dir    = p2_cmt;

   tron_dir_filter #(.DIR0(DIR_RIGHT)) u_p1_filter (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .req_valid (p1_req_ok),
      .req_dir   (dir_t'(p1_req_dir)),
      .commit    (commit),
      .pending   (p1_pend),
      .committed (p1_cmt)
   );

   tron_dir_filter #(.DIR0(DIR_LEFT)) u_p2_filter (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .req_valid (p2_req_ok),
      .req_dir   (dir_t'(p2_req_dir)),
      .commit    (commit),
      .pending   (p2_pend),
      .committed (p2_cmt)
   );

   // Off-grid moves keep the current cell so the read still has a legal address.
   function automatic void next_cell(input  dir_t           d,
                                     input  logic [X_W-1:0] x,
                                     input  logic [Y_W-1:0] y,
                                     output logic [X_W-1:0] nx,
                                     output logic [Y_W-1:0] ny,
                                     output logic           off);
      nx  = x;
      ny  = y;
      off = 1'b0;
      case (d)
         DIR_UP:    if (y == '0) off = 1'b1; else ny = y - Y_W'(1);
         DIR_RIGHT: if (x == X_W'(GRID_W - 1)) off = 1'b1; else nx = x + X_W'(1);
         DIR_DOWN:  if (y == Y_W'(GRID_H - 1)) off = 1'b1; else ny = y + Y_W'(1);
         DIR_LEFT:  if (x == '0) off = 1'b1; else nx = x - X_W'(1);
      endcase
   endfunction

   // The pending direction is the one committed on this tick.
   always_comb begin
      next_cell(p1_pend, p1_x, p1_y, c1_x, c1_y, c1_off);
      next_cell(p2_pend, p2_x, p2_y, c2_x, c2_y, c2_off);
   end

   assign same  = (n1_x == n2_x) && (n1_y == n2_y);
   assign dead1 = off1 | occ1 | same;
   assign dead2 = off2 | grid_rd_occ | same;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_INIT1;
         busy       <= 1'b1;
         grid_re    <= 1'b0;
         grid_we    <= 1'b0;
         grid_x     <= '0;
         grid_y     <= '0;
         grid_wr_id <= '0;
         p1_x       <= X_W'(P1_X0);
         p1_y       <= Y_W'(P1_Y0);
         p2_x       <= X_W'(P2_X0);
         p2_y       <= Y_W'(P2_Y0);
         n1_x       <= '0;
         n1_y       <= '0;
         n2_x       <= '0;
         n2_y       <= '0;
         off1       <= 1'b0;
         off2       <= 1'b0;
         occ1       <= 1'b0;
         game_over  <= 1'b0;
         winner     <= '0;
      end else begin
         grid_re <= 1'b0;
         grid_we <= 1'b0;
         case (state)
            ST_INIT1: begin
               grid_we    <= 1'b1;
               grid_x     <= X_W'(P1_X0);
               grid_y     <= Y_W'(P1_Y0);
               grid_wr_id <= ID_P1;
               state      <= ST_INIT2;
            end
            ST_INIT2: begin
               grid_we    <= 1'b1;
               grid_x     <= X_W'(P2_X0);
               grid_y     <= Y_W'(P2_Y0);
               grid_wr_id <= ID_P2;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            ST_IDLE: begin
               if (tick) begin
                  n1_x    <= c1_x;
                  n1_y    <= c1_y;
                  n2_x    <= c2_x;
                  n2_y    <= c2_y;
                  off1    <= c1_off;
                  off2    <= c2_off;
                  grid_re <= 1'b1;
                  grid_x  <= c1_x;
                  grid_y  <= c1_y;
                  busy    <= 1'b1;
                  state   <= ST_RD1;
               end
            end
            ST_RD1: begin
               grid_re <= 1'b1;
               grid_x  <= n2_x;
               grid_y  <= n2_y;
               state   <= ST_RD2;
            end
            ST_RD2: begin
               occ1  <= grid_rd_occ;
               state <= ST_CHK;
            end
            ST_CHK: begin
               if (dead1 || dead2) begin
                  game_over <= 1'b1;
                  winner    <= {dead1, dead2};
                  state     <= ST_DEAD;
               end else begin
                  grid_we    <= 1'b1;
                  grid_x     <= n1_x;
                  grid_y     <= n1_y;
                  grid_wr_id <= ID_P1;
                  state      <= ST_WR1;
               end
            end
            ST_WR1: begin
               grid_we    <= 1'b1;
               grid_x     <= n2_x;
               grid_y     <= n2_y;
               grid_wr_id <= ID_P2;
               state      <= ST_WR2;
            end
            ST_WR2: begin
               p1_x  <= n1_x;
               p1_y  <= n1_y;
               p2_x  <= n2_x;
               p2_y  <= n2_y;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_DEAD: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tron_move_ctrl.sv
// Bench for tron_move_ctrl: trail-grid RAM stand-in, step-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_tron_move_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       tick;
   logic       p1_req_valid, p2_req_valid;
   logic [1:0] p1_req_dir, p2_req_dir;
   logic [7:0] grid_x;
   logic [6:0] grid_y;
   logic       grid_re, grid_we, grid_rd_occ;
   logic [1:0] grid_wr_id;
   logic [7:0] p1_x, p2_x;
   logic [6:0] p1_y, p2_y;
   logic [1:0] p1_dir, p2_dir, winner;
   logic       busy, game_over;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tron_move_ctrl dut (
      .CLOCK_50     (clk),
      .resetn       (resetn),
      .tick         (tick),
      .p1_req_valid (p1_req_valid),
      .p2_req_valid (p2_req_valid),
      .p1_req_dir   (p1_req_dir),
      .p2_req_dir   (p2_req_dir),
      .grid_x       (grid_x),
      .grid_y       (grid_y),
      .grid_re      (grid_re),
      .grid_rd_occ  (grid_rd_occ),
      .grid_we      (grid_we),
      .grid_wr_id   (grid_wr_id),
      .p1_x         (p1_x),
      .p1_y         (p1_y),
      .p2_x         (p2_x),
      .p2_y         (p2_y),
      .p1_dir       (p1_dir),
      .p2_dir       (p2_dir),
      .busy         (busy),
      .game_over    (game_over),
      .winner       (winner)
   );

   function automatic void chk(input string nm, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
      end
   endfunction

   // Trail-grid RAM: registered read data, one cycle after grid_re.
   bit ram [0:159][0:119];
   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) ram[i][j] = 1'b0;
         grid_rd_occ <= 1'b0;
      end else begin
         if (grid_we && grid_x < 160 && grid_y < 120) ram[grid_x][grid_y] = 1'b1;
         grid_rd_occ <= (grid_re && grid_x < 160 && grid_y < 120) ? ram[grid_x][grid_y] : 1'b0;
      end
   end

   // Reference model: whole game step decided at tick time from its own grid.
   int dxs [4] = '{0, 1, 0, -1};
   int dys [4] = '{-1, 0, 1, 0};
   bit mocc [0:159][0:119];
   int m1x, m1y, m2x, m2y, mc1, mc2, mp1, mp2;
   int n1x, n1y, n2x, n2y, ic, stp;
   bit d1, d2, mdead;
   bit e_busy, e_re, e_we, e_go;
   int e_ax, e_ay, e_id, e_win;

   function automatic void adv(input int d, input int x, input int y,
                               output int nx, output int ny, output bit off);
      nx  = x + dxs[d];
      ny  = y + dys[d];
      off = (nx < 0) || (nx >= 160) || (ny < 0) || (ny >= 120);
      if (off) begin
         nx = x;
         ny = y;
      end
   endfunction

   always @(posedge clk) begin
      bit was_dead, o1, o2, same;
      int oc1, oc2;
      if (!resetn) begin
         for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) mocc[i][j] = 1'b0;
         mocc[20][60] = 1'b1;
         mocc[140][60] = 1'b1;
         m1x = 20; m1y = 60; m2x = 140; m2y = 60;
         mc1 = 1; mp1 = 1; mc2 = 3; mp2 = 3;
         ic = 2; stp = 0; mdead = 0;
         e_busy = 1; e_re = 0; e_we = 0; e_go = 0; e_win = 0;
         e_ax = 0; e_ay = 0; e_id = 0;
      end else begin
         was_dead = mdead;
         oc1 = mc1;
         oc2 = mc2;
         e_re = 0;
         e_we = 0;
         if (ic > 0) begin
            e_we = 1;
            e_ax = (ic == 2) ? 20 : 140;
            e_ay = 60;
            e_id = (ic == 2) ? 1 : 2;
            ic--;
            if (ic == 0) e_busy = 0;
         end else if (!mdead) begin
            case (stp)
               0: if (tick) begin
                  mc1 = mp1;
                  mc2 = mp2;
                  adv(mc1, m1x, m1y, n1x, n1y, o1);
                  adv(mc2, m2x, m2y, n2x, n2y, o2);
                  same = (n1x == n2x) && (n1y == n2y);
                  d1 = o1 || mocc[n1x][n1y] || same;
                  d2 = o2 || mocc[n2x][n2y] || same;
                  e_re = 1; e_ax = n1x; e_ay = n1y;
                  e_busy = 1;
                  stp = 1;
               end
               1: begin e_re = 1; e_ax = n2x; e_ay = n2y; stp = 2; end
               2: stp = 3;
               3: if (d1 || d2) begin
                  mdead = 1;
                  e_go = 1;
                  e_win = (d1 ? 2 : 0) + (d2 ? 1 : 0);
                  stp = 0;
               end else begin
                  e_we = 1; e_ax = n1x; e_ay = n1y; e_id = 1;
                  mocc[n1x][n1y] = 1'b1;
                  stp = 4;
               end
               4: begin
                  e_we = 1; e_ax = n2x; e_ay = n2y; e_id = 2;
                  mocc[n2x][n2y] = 1'b1;
                  stp = 5;
               end
               default: begin
                  m1x = n1x; m1y = n1y; m2x = n2x; m2y = n2y;
                  e_busy = 0;
                  stp = 0;
               end
            endcase
         end
         if (!was_dead) begin
            if (p1_req_valid && int'(p1_req_dir) != (oc1 ^ 2)) mp1 = p1_req_dir;
            if (p2_req_valid && int'(p2_req_dir) != (oc2 ^ 2)) mp2 = p2_req_dir;
         end
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         chk("busy", busy, e_busy);
         chk("grid_re", grid_re, e_re);
         chk("grid_we", grid_we, e_we);
         chk("re_we_exclusive", grid_re & grid_we, 0);
         if (e_re || e_we) begin
            chk("grid_x", grid_x, e_ax);
            chk("grid_y", grid_y, e_ay);
         end
         if (e_we) chk("grid_wr_id", grid_wr_id, e_id);
         chk("p1_x", p1_x, m1x);
         chk("p1_y", p1_y, m1y);
         chk("p2_x", p2_x, m2x);
         chk("p2_y", p2_y, m2y);
         chk("p1_dir", p1_dir, mc1);
         chk("p2_dir", p2_dir, mc2);
         chk("game_over", game_over, e_go);
         chk("winner", winner, e_win);
      end
   end

   task automatic do_reset();
      resetn = 1'b0;
      tick = 1'b0;
      p1_req_valid = 1'b0;
      p2_req_valid = 1'b0;
      p1_req_dir = 2'b00;
      p2_req_dir = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_p1_x", p1_x, 20);
      chk("rst_p2_x", p2_x, 140);
      chk("rst_p1_dir", p1_dir, 1);
      chk("rst_p2_dir", p2_dir, 3);
      chk("rst_busy", busy, 1);
      chk("rst_we_re", {grid_we, grid_re}, 0);
      chk("rst_over_win", {game_over, winner}, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("init1_write", {grid_we, grid_x, grid_y, grid_wr_id}, {1'b1, 8'd20, 7'd60, 2'b01});
      @(negedge clk);
      chk("init2_write", {grid_we, grid_x, grid_y, grid_wr_id}, {1'b1, 8'd140, 7'd60, 2'b10});
      @(negedge clk);
      chk("busy_low_cycle3", busy, 0);
   endtask

   task automatic req(input bit v1, input logic [1:0] r1, input bit v2, input logic [1:0] r2);
      @(negedge clk);
      p1_req_valid = v1; p1_req_dir = r1;
      p2_req_valid = v2; p2_req_dir = r2;
      @(negedge clk);
      p1_req_valid = 1'b0;
      p2_req_valid = 1'b0;
   endtask

   // Returns at cycle 6 of the step with the number of write cycles seen.
   task automatic step_one(output int we_cnt);
      we_cnt = 0;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (5) begin
         if (grid_we) we_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int w;
      resetn = 1'b0;

      // Reversal dropped, exact read/write schedule of one step.
      do_reset();
      req(1, 2'b11, 0, 2'b00);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("c1_read_p1", {grid_re, grid_x, grid_y}, {1'b1, 8'd21, 7'd60});
      @(negedge clk);
      chk("c2_read_p2", {grid_re, grid_x, grid_y}, {1'b1, 8'd139, 7'd60});
      chk("c2_p1_dir_kept", p1_dir, 1);
      @(negedge clk);
      chk("c3_idle_bus", {grid_re, grid_we, busy}, 3'b001);
      @(negedge clk);
      chk("c4_write_p1", {grid_we, grid_x, grid_y, grid_wr_id}, {1'b1, 8'd21, 7'd60, 2'b01});
      @(negedge clk);
      chk("c5_write_p2", {grid_we, grid_x, grid_y, grid_wr_id}, {1'b1, 8'd139, 7'd60, 2'b10});
      chk("c5_p1_x_old", p1_x, 20);
      @(negedge clk);
      chk("c6_p1_x", p1_x, 21);
      chk("c6_p2_x", p2_x, 139);
      chk("c6_busy", busy, 0);
      req(1, 2'b00, 0, 2'b00);
      step_one(w);
      chk("up_p1_xy", {p1_x, p1_y}, {8'd21, 7'd59});
      chk("up_p2_x", p2_x, 138);
      chk("up_writes", w, 2);

      // Tick during busy is dropped.
      do_reset();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (10) @(negedge clk);
      chk("drop_p1_x", p1_x, 21);
      chk("drop_p2_x", p2_x, 139);
      chk("drop_busy", busy, 0);

      // Head-on: equal next cells give a draw; DEAD ignores ticks and requests.
      do_reset();
      for (int i = 0; i < 59; i++) step_one(w);
      chk("pre_draw_x", {p1_x, p2_x}, {8'd79, 8'd81});
      step_one(w);
      chk("draw_over", game_over, 1);
      chk("draw_winner", winner, 3);
      chk("draw_no_write", w, 0);
      chk("draw_pos", {p1_x, p2_x}, {8'd79, 8'd81});
      repeat (3) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
      end
      req(1, 2'b00, 1, 2'b00);
      repeat (10) @(negedge clk);
      chk("dead_pos", {p1_x, p2_x}, {8'd79, 8'd81});
      chk("dead_dirs", {p1_dir, p2_dir}, {2'b01, 2'b11});
      chk("dead_flags", {busy, game_over, winner}, {1'b1, 1'b1, 2'b11});

      // P1 drives into the right wall on row 59; P2 survives.
      do_reset();
      req(1, 2'b00, 1, 2'b10);
      step_one(w);
      req(1, 2'b01, 0, 2'b00);
      for (int i = 0; i < 139; i++) begin
         if (i == 39) req(0, 2'b00, 1, 2'b11);
         step_one(w);
      end
      chk("wall_p1_xy", {p1_x, p1_y}, {8'd159, 7'd59});
      chk("wall_p2_xy", {p2_x, p2_y}, {8'd40, 7'd100});
      step_one(w);
      chk("wall_over", game_over, 1);
      chk("wall_winner", winner, 2);
      chk("wall_no_write", w, 0);
      chk("wall_p1_x_frozen", p1_x, 159);

      // Random steering and ticks against the model.
      for (int run = 0; run < 6; run++) begin
         do_reset();
         for (int c = 0; c < 2500 && !e_go; c++) begin
            @(negedge clk);
            tick = ($urandom_range(0, 3) == 0);
            p1_req_valid = ($urandom_range(0, 5) == 0);
            p2_req_valid = ($urandom_range(0, 5) == 0);
            p1_req_dir = 2'($urandom_range(0, 3));
            p2_req_dir = 2'($urandom_range(0, 3));
         end
         tick = 1'b0;
         p1_req_valid = 1'b0;
         p2_req_valid = 1'b0;
         repeat (8) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
